// File: rtl/dispatch1to4.sv
`default_nettype none
// ============================================================================
// Module      : dispatch1to4
// Description : Registered 1-to-4 dispatcher, addressed or round-robin routing,
//               exporting the live target as a select for a downstream demux.
// Revision    : 1.0
// ============================================================================
module dispatch1to4 #(
    parameter int DATA_W = 8
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [DATA_W-1:0]     in_data,
    input  logic [1:0]            in_dest,
    input  logic                  mode,
    output logic [3:0]            out_valid,
    input  logic [3:0]            out_ready,
    output logic [4*DATA_W-1:0]   out_data,
    output logic [1:0]            sel,
    output logic                  busy,
    output logic [15:0]           xfer_cnt
);

    localparam int c_NUM_CH = 4;

    logic [1:0]        r_rr_ptr;
    logic [3:0]        r_valid;
    logic [DATA_W-1:0] r_data [c_NUM_CH];
    logic [15:0]       r_xfer_cnt;

    logic [1:0]        w_tgt;
    logic              w_accept;

    assign w_tgt    = mode ? r_rr_ptr : in_dest;
    assign in_ready = ~r_valid[w_tgt] | out_ready[w_tgt];
    assign w_accept = in_valid & in_ready;

    assign sel       = w_tgt;
    assign out_valid = r_valid;
    assign busy      = |r_valid;
    assign xfer_cnt  = r_xfer_cnt;

    // A load on a channel wins over its pop, so a same-cycle pop+accept never bubbles.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_valid <= 4'b0000;
            for (int i = 0; i < c_NUM_CH; i++) begin
                r_data[i] <= '0;
            end
        end else begin
            for (int i = 0; i < c_NUM_CH; i++) begin
                if (w_accept && (w_tgt == 2'(i))) begin
                    r_valid[i] <= 1'b1;
                    r_data[i]  <= in_data;
                end else if (out_ready[i]) begin
                    r_valid[i] <= 1'b0;
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_rr_ptr   <= 2'd0;
            r_xfer_cnt <= 16'd0;
        end else if (w_accept) begin
            r_xfer_cnt <= r_xfer_cnt + 16'd1;
            if (mode) begin
                r_rr_ptr <= r_rr_ptr + 2'd1;
            end
        end
    end

    generate
        for (genvar gi = 0; gi < c_NUM_CH; gi++) begin : g_out_pack
            assign out_data[gi*DATA_W +: DATA_W] = r_data[gi];
        end
    endgenerate

endmodule
`default_nettype wire

// File: tb/tb_dispatch1to4.sv
`default_nettype none
// ============================================================================
// Module      : tb_dispatch1to4
// Description : Self-checking bench for dispatch1to4 (vector table + scoreboard).
// Revision    : 1.0
// ============================================================================
module tb_dispatch1to4;

    localparam int DW = 8;

    logic            clk = 1'b0;
    logic            rst_n;
    logic            in_valid;
    logic            in_ready;
    logic [DW-1:0]   in_data;
    logic [1:0]      in_dest;
    logic            mode;
    logic [3:0]      out_valid;
    logic [3:0]      out_ready;
    logic [4*DW-1:0] out_data;
    logic [1:0]      sel;
    logic            busy;
    logic [15:0]     xfer_cnt;

    dispatch1to4 #(.DATA_W(DW)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .in_dest   (in_dest),
        .mode      (mode),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .sel       (sel),
        .busy      (busy),
        .xfer_cnt  (xfer_cnt)
    );

    always #5 clk = ~clk;

    int tests = 0;
    int fails = 0;

    // Per-channel scoreboard: expected word pushed on accept, popped on consume.
    logic [DW-1:0] exp_q [4][$];
    logic [1:0]    m_rr;
    logic [15:0]   m_cnt;

    typedef struct {
        logic        m;
        logic [1:0]  d;
        logic [7:0]  data;
        logic [1:0]  exp_sel;
        logic [15:0] exp_cnt;
    } vec_t;

    vec_t tbl [10];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            if (fails <= 40)
                $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    initial begin : monitor
        logic [1:0] tgt;
        logic       mready;
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                for (int i = 0; i < 4; i++) exp_q[i].delete();
                m_rr  = 2'd0;
                m_cnt = 16'd0;
                chk("rst_out_valid", 32'(out_valid), 32'h0);
                chk("rst_xfer_cnt", 32'(xfer_cnt), 32'h0);
            end else begin
                tgt    = mode ? m_rr : in_dest;
                mready = (exp_q[tgt].size() == 0) || out_ready[tgt];
                chk("mon_sel", 32'(sel), 32'(tgt));
                chk("mon_in_ready", 32'(in_ready), 32'(mready));
                chk("mon_xfer_cnt", 32'(xfer_cnt), 32'(m_cnt));
                chk("mon_busy", 32'(busy), 32'(|out_valid));
                for (int i = 0; i < 4; i++) begin
                    chk("mon_out_valid", 32'(out_valid[i]), 32'(exp_q[i].size() != 0));
                    if (exp_q[i].size() != 0) begin
                        chk("mon_out_data", 32'(out_data[i*DW +: DW]), 32'(exp_q[i][0]));
                        if (out_ready[i]) void'(exp_q[i].pop_front());
                    end
                end
                if (in_valid && mready) begin
                    exp_q[tgt].push_back(in_data);
                    m_cnt = m_cnt + 16'd1;
                    if (mode) m_rr = m_rr + 2'd1;
                end
            end
        end
    end

    task automatic idle(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic reset_dut();
        @(posedge clk);
        #1;
        rst_n    = 1'b0;
        in_valid = 1'b0;
        idle(2);
        rst_n = 1'b1;
    endtask

    // Present one word and hold it until accepted; returns 1 time unit after the accepting edge.
    task automatic send(input logic m, input logic [1:0] d, input logic [7:0] data,
                        input logic [1:0] exp_sel, input string nm);
        int n;
        in_valid = 1'b1;
        mode     = m;
        in_dest  = d;
        in_data  = data;
        n        = 0;
        @(negedge clk);
        chk(nm, 32'(sel), 32'(exp_sel));
        while (!in_ready && n < 50) begin
            @(negedge clk);
            n++;
        end
        if (n >= 50) chk("send_timeout", 32'(n), 32'd0);
        @(posedge clk);
        #1;
        in_valid = 1'b0;
    endtask

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        tbl[0] = '{1'b1, 2'd0, 8'h10, 2'd0, 16'd0};
        tbl[1] = '{1'b1, 2'd0, 8'h11, 2'd1, 16'd1};
        tbl[2] = '{1'b1, 2'd0, 8'h12, 2'd2, 16'd2};
        tbl[3] = '{1'b1, 2'd0, 8'h13, 2'd3, 16'd3};
        tbl[4] = '{1'b1, 2'd0, 8'h14, 2'd0, 16'd4};
        tbl[5] = '{1'b0, 2'd3, 8'h20, 2'd3, 16'd5};
        tbl[6] = '{1'b0, 2'd1, 8'h21, 2'd1, 16'd6};
        tbl[7] = '{1'b0, 2'd0, 8'h22, 2'd0, 16'd7};
        tbl[8] = '{1'b0, 2'd2, 8'h23, 2'd2, 16'd8};
        tbl[9] = '{1'b1, 2'd3, 8'h24, 2'd1, 16'd9};

        // Reset held with a word offered.
        rst_n     = 1'b0;
        in_valid  = 1'b1;
        mode      = 1'b1;
        in_dest   = 2'd3;
        in_data   = 8'h77;
        out_ready = 4'b0000;
        repeat (2) begin
            @(negedge clk);
            chk("reset_out_valid", 32'(out_valid), 32'h0);
            chk("reset_sel", 32'(sel), 32'h0);
            chk("reset_busy", 32'(busy), 32'h0);
            chk("reset_in_ready", 32'(in_ready), 32'h1);
            chk("reset_out_data", out_data, 32'h0);
        end
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        chk("first_accept_valid", 32'(out_valid), 32'h1);
        chk("first_accept_data", 32'(out_data[7:0]), 32'h77);

        // Vector table: round-robin then addressed then resume.
        out_ready = 4'b1111;
        reset_dut();
        foreach (tbl[k]) begin
            chk("tbl_cnt", 32'(xfer_cnt), 32'(tbl[k].exp_cnt));
            send(tbl[k].m, tbl[k].d, tbl[k].data, tbl[k].exp_sel, "tbl_sel");
        end
        chk("tbl_final_cnt", 32'(xfer_cnt), 32'd10);
        chk("tbl_last_data", 32'(out_data[1*DW +: DW]), 32'h24);
        idle(2);

        // Addressed backpressure on channel 2.
        reset_dut();
        out_ready = 4'b1011;
        send(1'b0, 2'd2, 8'hA5, 2'd2, "bp_sel1");
        in_valid = 1'b1;
        mode     = 1'b0;
        in_dest  = 2'd2;
        in_data  = 8'h5A;
        repeat (3) begin
            @(negedge clk);
            chk("bp_in_ready_low", 32'(in_ready), 32'h0);
            chk("bp_hold_data", 32'(out_data[2*DW +: DW]), 32'hA5);
        end
        @(posedge clk);
        #1;
        out_ready = 4'b1111;
        @(negedge clk);
        chk("bp_in_ready_high", 32'(in_ready), 32'h1);
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        @(negedge clk);
        chk("bp_valid_kept", 32'(out_valid[2]), 32'h1);
        chk("bp_new_data", 32'(out_data[2*DW +: DW]), 32'h5A);
        chk("bp_cnt", 32'(xfer_cnt), 32'd2);
        idle(2);

        // Mode switch keeps the round-robin pointer.
        reset_dut();
        send(1'b1, 2'd3, 8'h30, 2'd0, "ms_rr0");
        send(1'b1, 2'd3, 8'h31, 2'd1, "ms_rr1");
        send(1'b0, 2'd0, 8'h40, 2'd0, "ms_addr");
        send(1'b0, 2'd0, 8'h41, 2'd0, "ms_addr");
        send(1'b0, 2'd0, 8'h42, 2'd0, "ms_addr");
        send(1'b1, 2'd0, 8'h50, 2'd2, "ms_resume_sel");
        chk("ms_resume_data", 32'(out_data[2*DW +: DW]), 32'h50);
        idle(2);

        // Fill all four, then drain all in one cycle.
        reset_dut();
        out_ready = 4'b0000;
        for (int i = 0; i < 4; i++)
            send(1'b1, 2'd0, 8'(8'hC0 + i), 2'(i), "drain_fill_sel");
        chk("drain_full", 32'(out_valid), 32'hF);
        chk("drain_busy_full", 32'(busy), 32'h1);
        out_ready = 4'b1111;
        idle(1);
        chk("drain_empty", 32'(out_valid), 32'h0);
        chk("drain_busy_empty", 32'(busy), 32'h0);
        chk("drain_data_held", 32'(out_data[3*DW +: DW]), 32'hC3);

        // Reset mid-operation discards buffered words at once.
        out_ready = 4'b0000;
        for (int i = 0; i < 4; i++)
            send(1'b1, 2'd0, 8'(8'hE0 + i), 2'(i), "mid_fill_sel");
        #2;
        rst_n = 1'b0;
        #1;
        chk("mid_rst_valid", 32'(out_valid), 32'h0);
        chk("mid_rst_cnt", 32'(xfer_cnt), 32'h0);
        chk("mid_rst_data", out_data, 32'h0);
        @(posedge clk);
        #1;
        rst_n     = 1'b1;
        out_ready = 4'b1111;
        send(1'b1, 2'd3, 8'h66, 2'd0, "mid_rst_rr_sel");
        idle(2);

        // Counter wrap after 65536 streamed accepts.
        reset_dut();
        mode     = 1'b1;
        in_valid = 1'b1;
        for (int i = 0; i < 65536; i++) begin
            in_data = 8'(i);
            @(posedge clk);
            #1;
        end
        in_valid = 1'b0;
        chk("wrap_cnt", 32'(xfer_cnt), 32'h0);
        send(1'b1, 2'd2, 8'h99, 2'd0, "wrap_route_sel");
        chk("wrap_route_data", 32'(out_data[7:0]), 32'h99);
        chk("wrap_cnt_after", 32'(xfer_cnt), 32'h1);
        idle(3);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/dispatch1to4.md
# dispatch1to4

Registered 1-to-4 dispatcher that sits directly upstream of the combinational 1-to-4 demux. It accepts a single valid/ready input stream and routes each accepted word to one of four registered output channels. A word goes to the channel named by its destination field, or to the next channel in round-robin order. It also exports the current target as a 2-bit select so the downstream demux can be steered in lockstep.

## Interface
- DATA_W, default 8: width of each data word.
- clk  input  1  rising-edge clock, single clock domain.
- rst_n  input  1  asynchronous, active-low reset.
- in_valid  input  1  input word present.
- in_ready  output  1  dispatcher can accept this cycle.
- in_data  input  DATA_W  input word.
- in_dest  input  2  destination channel; used only when mode=0.
- mode  input  1  0 = addressed (use in_dest), 1 = round-robin.
- out_valid  output  4  per-channel word valid; bit i belongs to channel i.
- out_ready  input  4  per-channel consumer ready.
- out_data  output  4*DATA_W  channel i occupies bits [i*DATA_W +: DATA_W].
- sel  output  2  current target channel {s1,s0} for the downstream demux.
- busy  output  1  OR of out_valid.
- xfer_cnt  output  16  count of accepted input words; wraps.

## Operation
- Target selection (combinational):
  - tgt = in_dest when mode=0.
  - tgt = rr_ptr when mode=1.
  - sel = tgt at all times, including when in_valid=0.
- Each channel is a one-entry register holding out_valid[i] and its data word.
- in_ready = ~out_valid[tgt] | out_ready[tgt]. This is a combinational path from out_ready and mode/in_dest to in_ready, and it is permitted.
- Accept occurs when in_valid & in_ready. On accept:
  - Channel tgt loads in_data and sets out_valid[tgt]=1.
  - xfer_cnt increments by 1 and wraps from 0xFFFF to 0.
  - If mode=1, rr_ptr advances to rr_ptr+1 mod 4 (3 -> 0).
- Pop of channel i occurs when out_valid[i] & out_ready[i]. Pop clears out_valid[i] unless the same cycle also accepts into channel i.
- Simultaneous pop and accept on the same channel: the new word replaces the old one, out_valid stays 1, and there is no bubble.
- Pops on other channels are independent, so all four channels may pop in the same cycle.
- Addressed mode never modifies rr_ptr. Switching mode never resets rr_ptr, and round-robin resumes from its held value.
- A blocked target stalls the input. No word is ever dropped or re-routed to another channel.
- in_data and in_dest are ignored when in_valid=0.
- out_data[i] holds its last value after a pop and is not cleared.

## Timing
- Reset (asynchronous assert, synchronous-safe deassert on clk) sets:
  - out_valid = 4'b0000 and all out_data = 0.
  - rr_ptr = 0, so sel = 0 when mode=1.
  - xfer_cnt = 0 and busy = 0.
- While in reset, in_ready follows its equation. With out_valid=0 it reads 1, but no accept occurs until rst_n=1.
- Latency: a word accepted in cycle N appears on out_valid[tgt]/out_data in cycle N+1.
- Throughput: one word per cycle, provided the targets are free or popping.
- Reset asserted mid-operation discards all buffered words immediately, with no partial state retained.
- xfer_cnt and rr_ptr update on the same edge as the accept.

## Test plan
- Reset: hold rst_n=0 with in_valid=1. Required: out_valid=0000, xfer_cnt=0, sel=0 in round-robin mode. After release, the first accept lands in channel 0.
- Round-robin: mode=1, out_ready=1111, send words 0x10,0x11,0x12,0x13,0x14 on consecutive cycles. Required: channels 0,1,2,3,0 each receive the matching word one cycle later, and xfer_cnt=5.
- Addressed backpressure: mode=0, out_ready[2]=0. Send 0xA5 with dest=2, then 0x5A with dest=2. Required:
  - in_ready drops after the first accept.
  - The second word waits until out_ready[2]=1.
  - Channel 2 then pops 0xA5 and loads 0x5A in the same cycle, and out_valid[2] stays 1.
- Mode switch: mode=1, send 2 words (rr_ptr=2). Switch to mode=0 and send 3 words to dest=0. Switch back to mode=1. Required: the next word goes to channel 2.
- Independent drain: fill all four channels, then assert out_ready=1111 with in_valid=0. Required: out_valid=0000 next cycle and busy=0.
- Wrap: preload or stream 65536 accepts. Required: xfer_cnt=0 and no change in routing.
